output_buffer_bank: RTL and testbench

- Write-side counterpart of the input line buffer. It collects per-column results from the systolic wrapper, where columns arrive staggered in wavefront order.
- Results are assembled into full output rows in a ping-pong pair of row slots.
- Each completed row is serialised into the selected SRAM channel bank, one word per cycle, at incrementing addresses.
- It sits between the systolic array wrapper and the feature-map SRAM banks.

---
 rtl/output_buffer_bank.sv | 252 +++++++++++++++++++++++++
 tb/tb_output_buffer_bank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_bank.sv
// output_buffer_bank
//   Collects per-column results from the systolic array wrapper and assembles
//   them into full output rows. Two row slots form a ping-pong pair. Columns may
//   arrive staggered in wavefront order. Each completed row is serialised into
//   the selected feature-map SRAM channel bank, one word per cycle, at
//   incrementing addresses that continue across rows.
//
//   Optional build macro: OB_RELU_EN. When it is defined, negative words are
//   written as zero. When it is undefined, words pass through unchanged.
//
// Ports
//   clk_i, rst_sync_i   clock; synchronous active-high reset
//   start_i             begin a frame (IDLE only); samples cfg_* and output_ch_sel_i
//   abort_i             return to IDLE and empty both slots; error_o is kept
//   cfg_out_w_i         row width, 1..BANK_WIDTH
//   cfg_out_h_i         row count, >= 1
//   cfg_base_addr_i     first SRAM write address
//   output_ch_sel_i     target channel bank, < N_CH
//   push_i, data_in_i   per-column result valid / data
//   ob_ready_o          fill slot can accept pushes
//   sram_wr_en_o        one-hot SRAM write enable
//   sram_wr_addr_o      SRAM write address
//   sram_wr_data_o      SRAM write data
//   frame_done_o        one-cycle pulse after the last row has been written
//   error_o             sticky: overflow or illegal configuration
module output_buffer_bank #(
   parameter int BANK_WIDTH = 32,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int N_CH       = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_sync_i,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [31:0]                  cfg_out_w_i,
   input  logic [31:0]                  cfg_out_h_i,
   input  logic [ADDR_W-1:0]            cfg_base_addr_i,
   input  logic [2:0]                   output_ch_sel_i,
   input  logic [BANK_WIDTH-1:0]        push_i,
   input  logic [BANK_WIDTH*DATA_W-1:0] data_in_i,
   output logic                         ob_ready_o,
   output logic [N_CH-1:0]              sram_wr_en_o,
   output logic [ADDR_W-1:0]            sram_wr_addr_o,
   output logic [DATA_W-1:0]            sram_wr_data_o,
   output logic                         frame_done_o,
   output logic                         error_o
);

   localparam int COL_W = (BANK_WIDTH > 1) ? $clog2(BANK_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t                   state_q, state_d;
   logic [31:0]              w_q, w_d, h_q, h_d, rows_q, rows_d;
   logic [2:0]               ch_q, ch_d;
   logic [ADDR_W-1:0]        addr_q, addr_d, wr_addr_q, wr_addr_d;
   logic [N_CH-1:0]          wr_en_q, wr_en_d;
   logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
   logic                     fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;
   logic [1:0]               full_q, full_d;
   logic [BANK_WIDTH-1:0]    valid_q [2];
   logic [BANK_WIDTH-1:0]    valid_d [2];
   logic signed [DATA_W-1:0] slot_q [2][BANK_WIDTH];
   logic signed [DATA_W-1:0] slot_d [2][BANK_WIDTH];
   logic [COL_W-1:0]         col_q, col_d, issue_col;
   logic                     err_q, err_d;

   logic [BANK_WIDTH-1:0]    col_mask;
   logic                     cfg_legal, collecting, ready, row_last, frame_end;
   logic                     issue_first, issue_next, issue_sel;

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef OB_RELU_EN
      relu = x[DATA_W-1] ? '0 : x;
`else
      relu = x;
`endif
   endfunction

   always_comb begin
      col_mask = '0;
      for (int i = 0; i < BANK_WIDTH; i++) col_mask[i] = (32'(i) < w_q);
   end

   assign cfg_legal  = (cfg_out_w_i != 32'd0) && (cfg_out_w_i <= 32'(BANK_WIDTH)) &&
                       (cfg_out_h_i != 32'd0) && ({29'd0, output_ch_sel_i} < 32'(N_CH));
   assign collecting = (state_q == COLLECT) || (state_q == DRAIN);
   assign ready      = collecting && !full_q[fill_sel_q];

   // col_q is the column whose write is currently on the outputs.
   assign row_last    = (state_q == DRAIN) && (32'(col_q) == w_q - 32'd1);
   assign frame_end   = row_last && (rows_q + 32'd1 >= h_q);
   // A new row starts either from COLLECT or straight after the previous row,
   // so two full slots drain back-to-back without a bubble.
   assign issue_first = ((state_q == COLLECT) && full_q[drain_sel_q]) ||
                        (row_last && !frame_end && full_q[!drain_sel_q]);
   assign issue_next  = (state_q == DRAIN) && !row_last;
   assign issue_sel   = row_last ? !drain_sel_q : drain_sel_q;
   assign issue_col   = issue_first ? '0 : col_q + COL_W'(1);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_sync_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i && cfg_legal) state_d = COLLECT;
            COLLECT: if (full_q[drain_sel_q]) state_d = DRAIN;
            DRAIN:   if (row_last) state_d = frame_end ? DONE :
                                             (full_q[!drain_sel_q] ? DRAIN : COLLECT);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Capture, drain and output register next values
   always_comb begin
      w_d         = w_q;
      h_d         = h_q;
      ch_d        = ch_q;
      rows_d      = rows_q;
      addr_d      = addr_q;
      fill_sel_d  = fill_sel_q;
      drain_sel_d = drain_sel_q;
      full_d      = full_q;
      valid_d     = valid_q;
      slot_d      = slot_q;
      col_d       = col_q;
      err_d       = err_q;
      wr_en_d     = '0;
      wr_addr_d   = '0;
      wr_data_d   = '0;

      if ((state_q == IDLE) && start_i) begin
         if (cfg_legal) begin
            w_d    = cfg_out_w_i;
            h_d    = cfg_out_h_i;
            ch_d   = output_ch_sel_i;
            addr_d = cfg_base_addr_i;
            rows_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end

      // Columns at or beyond the row width are ignored. Overflowing pushes are dropped.
      if (collecting) begin
         for (int i = 0; i < BANK_WIDTH; i++) begin
            if (push_i[i] && col_mask[i]) begin
               if (!ready || valid_q[fill_sel_q][i]) begin
                  err_d = 1'b1;
               end else begin
                  valid_d[fill_sel_q][i] = 1'b1;
                  slot_d[fill_sel_q][i]  = data_in_i[i*DATA_W +: DATA_W];
               end
            end
         end
         if (ready && ((valid_d[fill_sel_q] & col_mask) == col_mask)) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = !fill_sel_q;
         end
      end else if (push_i != '0) begin
         err_d = 1'b1;
      end

      if (issue_first || issue_next) begin
         wr_en_d[ch_q] = 1'b1;
         wr_addr_d     = addr_q;
         addr_d        = addr_q + ADDR_W'(1);
         wr_data_d     = relu(slot_q[issue_sel][issue_col]);
         col_d         = issue_col;
      end

      if (row_last) begin
         valid_d[drain_sel_q] = '0;
         full_d[drain_sel_q]  = 1'b0;
         drain_sel_d          = !drain_sel_q;
         rows_d               = rows_q + 32'd1;
      end

      if (abort_i) begin
         valid_d     = '{default: '0};
         full_d      = '0;
         fill_sel_d  = 1'b0;
         drain_sel_d = 1'b0;
         rows_d      = '0;
         addr_d      = '0;
         col_d       = '0;
         wr_en_d     = '0;
         wr_addr_d   = '0;
         wr_data_d   = '0;
         err_d       = err_q;
      end
   end

   // Control and output registers
   always_ff @(posedge clk_i) begin
      if (rst_sync_i) begin
         w_q         <= '0;
         h_q         <= '0;
         ch_q        <= '0;
         rows_q      <= '0;
         addr_q      <= '0;
         fill_sel_q  <= 1'b0;
         drain_sel_q <= 1'b0;
         full_q      <= '0;
         valid_q     <= '{default: '0};
         col_q       <= '0;
         err_q       <= 1'b0;
         wr_en_q     <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         w_q         <= w_d;
         h_q         <= h_d;
         ch_q        <= ch_d;
         rows_q      <= rows_d;
         addr_q      <= addr_d;
         fill_sel_q  <= fill_sel_d;
         drain_sel_q <= drain_sel_d;
         full_q      <= full_d;
         valid_q     <= valid_d;
         col_q       <= col_d;
         err_q       <= err_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Slot storage; contents are qualified by valid_q so they need no reset.
   always_ff @(posedge clk_i) begin
      slot_q <= slot_d;
   end

   assign ob_ready_o     = ready;
   assign sram_wr_en_o   = wr_en_q;
   assign sram_wr_addr_o = wr_addr_q;
   assign sram_wr_data_o = wr_data_q;
   assign frame_done_o   = (state_q == DONE);
   assign error_o        = err_q;

endmodule

// File: tb/tb_output_buffer_bank.sv
module tb_output_buffer_bank;
   localparam int BW = 32;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int NC = 8;

   logic              clk = 1'b0;
   logic              rst, start, abort_s;
   logic [31:0]       cfg_w, cfg_h;
   logic [AW-1:0]     cfg_base;
   logic [2:0]        ch;
   logic [BW-1:0]     push;
   logic [BW*DW-1:0]  din;
   logic              ob_ready_o, frame_done_o, error_o;
   logic [NC-1:0]     sram_wr_en_o;
   logic [AW-1:0]     sram_wr_addr_o;
   logic [DW-1:0]     sram_wr_data_o;

   typedef struct packed {
      logic [NC-1:0] en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk = 0, n_fail = 0;
   int  wr_count = 0, done_count = 0, run_cur = 0, last_run = 0;
   bit  mon_en = 1'b0;

   always #5 clk = ~clk;

   output_buffer_bank dut (
      .clk_i(clk), .rst_sync_i(rst), .start_i(start), .abort_i(abort_s),
      .cfg_out_w_i(cfg_w), .cfg_out_h_i(cfg_h), .cfg_base_addr_i(cfg_base),
      .output_ch_sel_i(ch), .push_i(push), .data_in_i(din),
      .ob_ready_o(ob_ready_o), .sram_wr_en_o(sram_wr_en_o),
      .sram_wr_addr_o(sram_wr_addr_o), .sram_wr_data_o(sram_wr_data_o),
      .frame_done_o(frame_done_o), .error_o(error_o)
   );

   // Scoreboard: every SRAM write is popped and compared against the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sram_wr_en_o != '0) begin
            wr_t e;
            wr_count++;
            run_cur++;
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sram_write unexpected: en=%0h addr=%0h data=%0h", sram_wr_en_o,
                        sram_wr_addr_o, sram_wr_data_o);
            end else begin
               e = exp_q.pop_front();
               if (sram_wr_en_o !== e.en || sram_wr_addr_o !== e.addr || sram_wr_data_o !== e.data) begin
                  n_fail++;
                  $display("FAIL sram_write got en=%0h addr=%0h data=%0h required en=%0h addr=%0h data=%0h",
                           sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o, e.en, e.addr, e.data);
               end
            end
         end else begin
            if (run_cur > 0) last_run = run_cur;
            run_cur = 0;
         end
         if (frame_done_o === 1'b1) done_count++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; start = 1'b0; abort_s = 1'b0; push = '0; din = '0;
      cfg_w = '0; cfg_h = '0; cfg_base = '0; ch = '0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic start_frame(input int w, input int h, input logic [AW-1:0] base, input int c);
      cfg_w = 32'(w); cfg_h = 32'(h); cfg_base = base; ch = 3'(c);
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic exp_push(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.en   = NC'(1) << c;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Waits until the scoreboard is empty and a new frame_done pulse has been seen.
   task automatic wait_frame(input int d0, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (exp_q.size() == 0 && done_count > d0) begin
            ok = 1'b1;
            break;
         end
         tick;
      end
   endtask

   task automatic test_reset;
      do_reset;
      mon_en = 1'b1;
      n_chk++; if (ob_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ob_ready got %b required 0", ob_ready_o); end
      n_chk++; if (sram_wr_en_o !== '0) begin n_fail++; $display("FAIL reset_wr_en got %0h required 0", sram_wr_en_o); end
      n_chk++; if (sram_wr_addr_o !== '0 || sram_wr_data_o !== '0) begin n_fail++;
         $display("FAIL reset_addr_data got %0h/%0h required 0/0", sram_wr_addr_o, sram_wr_data_o); end
      n_chk++; if (frame_done_o !== 1'b0 || error_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_done_err got %b/%b required 0/0", frame_done_o, error_o); end
   endtask

   task automatic test_single_row;
      int d0, w0;
      bit ok;
      do_reset;
      d0 = done_count; w0 = wr_count;
      start_frame(4, 1, 16'h10, 2);
      for (int i = 0; i < 4; i++) exp_push(2, AW'(16'h10 + i), DW'((i + 1) * 10));
      for (int k = 3; k >= 0; k--) begin
         push = BW'(1) << k;
         din[k*DW +: DW] = DW'((k + 1) * 10);
         tick;
      end
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_row_timeout pending=%0d required 0", exp_q.size()); end
      repeat (3) tick;
      n_chk++; if (done_count - d0 != 1) begin n_fail++; $display("FAIL single_row_done_pulses got %0d required 1", done_count - d0); end
      n_chk++; if (wr_count - w0 != 4) begin n_fail++; $display("FAIL single_row_writes got %0d required 4", wr_count - w0); end
      n_chk++; if (last_run != 4) begin n_fail++; $display("FAIL single_row_burst got %0d required 4", last_run); end
      n_chk++; if (ob_ready_o !== 1'b0 || error_o !== 1'b0) begin n_fail++;
         $display("FAIL single_row_idle ready/err got %b/%b required 0/0", ob_ready_o, error_o); end
   endtask

   task automatic test_ping_pong;
      int d0, w0;
      bit ok;
      do_reset;
      d0 = done_count; w0 = wr_count;
      start_frame(8, 3, 16'h0, 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 8; c++) exp_push(0, AW'(r * 8 + c), DW'(r * 100 + c + 1));
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 10; c++) begin
            n_chk++;
            if (ob_ready_o !== 1'b1) begin n_fail++;
               $display("FAIL ping_pong_ready row %0d step %0d got %b required 1", r, c, ob_ready_o); end
            if (c < 8) begin
               push = BW'(1) << c;
               din[c*DW +: DW] = DW'(r * 100 + c + 1);
            end else begin
               push = '0;
            end
            tick;
         end
      end
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL ping_pong_timeout pending=%0d required 0", exp_q.size()); end
      n_chk++; if (wr_count - w0 != 24) begin n_fail++; $display("FAIL ping_pong_writes got %0d required 24", wr_count - w0); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL ping_pong_error got %b required 0", error_o); end
   endtask

   task automatic test_overflow;
      int d0;
      bit ok;
      do_reset;
      d0 = done_count;
      start_frame(2, 2, 16'h20, 1);
      exp_push(1, 16'h20, 32'd11);
      exp_push(1, 16'h21, 32'd12);
      exp_push(1, 16'h22, 32'd21);
      exp_push(1, 16'h23, 32'd22);
      push = 2'b11; din[0 +: DW] = 32'd11; din[DW +: DW] = 32'd12;
      tick;
      din[0 +: DW] = 32'd21; din[DW +: DW] = 32'd22;
      tick;
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL overflow_early_error got %b required 0", error_o); end
      push = 2'b01; din[0 +: DW] = 32'd99;
      tick;
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL overflow_timeout pending=%0d required 0", exp_q.size()); end
      n_chk++; if (error_o !== 1'b1) begin n_fail++; $display("FAIL overflow_error got %b required 1", error_o); end
   endtask

   task automatic test_illegal_cfg;
      int w0;
      do_reset;
      w0 = wr_count;
      start_frame(BW + 1, 1, 16'h0, 0);
      repeat (5) tick;
      n_chk++; if (ob_ready_o !== 1'b0 || error_o !== 1'b1) begin n_fail++;
         $display("FAIL illegal_width ready/err got %b/%b required 0/1", ob_ready_o, error_o); end
      n_chk++; if (wr_count != w0) begin n_fail++; $display("FAIL illegal_width_writes got %0d required 0", wr_count - w0); end
      do_reset;
      start_frame(4, 0, 16'h0, 0);
      tick;
      n_chk++; if (ob_ready_o !== 1'b0 || error_o !== 1'b1) begin n_fail++;
         $display("FAIL illegal_height ready/err got %b/%b required 0/1", ob_ready_o, error_o); end
   endtask

   task automatic test_abort;
      int seen, d0, w0;
      bit ok;
      do_reset;
      start_frame(16, 2, 16'h40, 5);
      for (int i = 0; i < 5; i++) exp_push(5, AW'(16'h40 + i), DW'(1000 + i));
      push = 32'h0000_FFFF;
      for (int i = 0; i < 16; i++) din[i*DW +: DW] = DW'(1000 + i);
      tick;
      push = '0;
      seen = 0;
      for (int t = 0; t < 40 && seen < 5; t++) begin
         @(negedge clk);
         if (sram_wr_en_o != '0) seen++;
      end
      n_chk++; if (seen != 5) begin n_fail++; $display("FAIL abort_prefix_writes got %0d required 5", seen); end
      abort_s = 1'b1;
      @(posedge clk);
      #1;
      abort_s = 1'b0;
      @(negedge clk);
      n_chk++; if (sram_wr_en_o !== '0) begin n_fail++; $display("FAIL abort_wr_en got %0h required 0", sram_wr_en_o); end
      tick;
      n_chk++; if (ob_ready_o !== 1'b0 || exp_q.size() != 0) begin n_fail++;
         $display("FAIL abort_idle ready/pending got %b/%0d required 0/0", ob_ready_o, exp_q.size()); end
      d0 = done_count;
      start_frame(4, 1, 16'h100, 5);
      for (int i = 0; i < 4; i++) exp_push(5, AW'(16'h100 + i), DW'(2000 + i));
      push = 32'h7;
      for (int i = 0; i < 3; i++) din[i*DW +: DW] = DW'(2000 + i);
      tick;
      push = '0;
      w0 = wr_count;
      repeat (4) tick;
      n_chk++; if (wr_count != w0) begin n_fail++; $display("FAIL abort_stale_write got %0d required 0", wr_count - w0); end
      push = 32'h8; din[3*DW +: DW] = 32'd2003;
      tick;
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout pending=%0d required 0", exp_q.size()); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL abort_error got %b required 0", error_o); end
   endtask

   task automatic test_wrap_and_ignore;
      int d0;
      bit ok;
      do_reset;
      d0 = done_count;
      start_frame(4, 1, 16'hFFFE, 7);
      for (int i = 0; i < 4; i++) exp_push(7, AW'(16'hFFFE + i), DW'(500 + i));
      push = '1;
      for (int i = 0; i < BW; i++) din[i*DW +: DW] = DW'(500 + i);
      tick;
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout pending=%0d required 0", exp_q.size()); end
      n_chk++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL wrap_ignored_cols_error got %b required 0", error_o); end
   endtask

   task automatic test_relu;
      int d0;
      bit ok;
      logic [DW-1:0] neg;
      do_reset;
      d0 = done_count;
      neg = -32'sd5;
      start_frame(2, 1, 16'h30, 3);
`ifdef OB_RELU_EN
      exp_push(3, 16'h30, 32'd0);
`else
      exp_push(3, 16'h30, neg);
`endif
      exp_push(3, 16'h31, 32'd7);
      push = 2'b11; din[0 +: DW] = neg; din[DW +: DW] = 32'd7;
      tick;
      push = '0;
      wait_frame(d0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL relu_timeout pending=%0d required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset;
      test_single_row;
      test_ping_pong;
      test_overflow;
      test_illegal_cfg;
      test_abort;
      test_wrap_and_ignore;
      test_relu;
      repeat (3) tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
